// File: rtl/rx_shift_sequencer.sv
// USB RX shift-register sequencer: bit gating, unstuffing, SYNC check, byte/EOP framing.
// Optional macro RX_TIMEOUT_EN adds an idle-bit timeout that forces ERR.
`timescale 1ns/1ps
module rx_shift_sequencer #(
    parameter logic [7:0]  SYNC_BYTE = 8'h80,
    parameter int unsigned STUFF_LEN = 6,
    parameter int unsigned MAX_BYTES = 67,
    localparam int unsigned BC_W     = $clog2(MAX_BYTES + 1)
`ifdef RX_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            i_start_detect,
    input  logic            i_bit_strobe,
    input  logic            i_d_bit,
    input  logic            i_eop,
    input  logic [7:0]      i_rx_byte,
    output logic            o_shift_enable,
    output logic            o_byte_ready,
    output logic            o_packet_done,
    output logic            o_receiving,
    output logic            o_rx_error,
    output logic [BC_W-1:0] o_byte_count
);
    localparam int unsigned ONES_W = $clog2(STUFF_LEN + 1);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_CHK, S_RECV, S_ERR} state_t;

    state_t              r_state, w_state_nxt;
    logic [2:0]          r_bit_cnt, w_bit_cnt_nxt;
    logic [ONES_W-1:0]   r_ones_cnt, w_ones_cnt_nxt;
    logic [BC_W-1:0]     r_byte_count, w_byte_count_nxt;
    logic                r_rx_error, w_rx_error_nxt;
    logic                r_byte_ready, w_byte_ready_nxt;
    logic                r_packet_done, w_packet_done_nxt;
    logic                r_receiving, w_receiving_nxt;
    logic                w_active, w_sync_ok, w_accept, w_stuff_err, w_shift, w_timeout;

    assign w_active  = (r_state == S_SYNC) || (r_state == S_CHK) || (r_state == S_RECV);
    assign w_sync_ok = (i_rx_byte == SYNC_BYTE);

`ifdef RX_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES);
    logic [IDLE_W-1:0] r_idle_cnt;

    assign w_timeout = (r_idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    // Cycles since the last strobe while a packet is in flight
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_idle_cnt <= '0;
        end else if (!w_active || i_bit_strobe) begin
            r_idle_cnt <= '0;
        end else if (!w_timeout) begin
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= '0;
            r_ones_cnt    <= '0;
            r_byte_count  <= '0;
            r_rx_error    <= 1'b0;
            r_byte_ready  <= 1'b0;
            r_packet_done <= 1'b0;
            r_receiving   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_ones_cnt    <= w_ones_cnt_nxt;
            r_byte_count  <= w_byte_count_nxt;
            r_rx_error    <= w_rx_error_nxt;
            r_byte_ready  <= w_byte_ready_nxt;
            r_packet_done <= w_packet_done_nxt;
            r_receiving   <= w_receiving_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_bit_cnt_nxt     = r_bit_cnt;
        w_ones_cnt_nxt    = r_ones_cnt;
        w_byte_count_nxt  = r_byte_count;
        w_rx_error_nxt    = r_rx_error;
        w_byte_ready_nxt  = 1'b0;
        w_packet_done_nxt = 1'b0;
        w_accept          = 1'b0;
        w_stuff_err       = 1'b0;
        w_shift           = 1'b0;

        // Bit acceptance; eop masks the strobe, a failed SYNC check blocks shifting
        if (w_active && !i_eop && i_bit_strobe && !((r_state == S_CHK) && !w_sync_ok)) begin
            if (r_ones_cnt == ONES_W'(STUFF_LEN)) begin
                if (i_d_bit) begin
                    w_stuff_err = 1'b1;
                end else begin
                    w_ones_cnt_nxt = '0;
                end
            end else begin
                w_accept       = 1'b1;
                w_shift        = 1'b1;
                w_ones_cnt_nxt = i_d_bit ? r_ones_cnt + ONES_W'(1) : '0;
                w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (i_start_detect) begin
                    w_state_nxt      = S_SYNC;
                    w_rx_error_nxt   = 1'b0;
                    w_byte_count_nxt = '0;
                    w_bit_cnt_nxt    = '0;
                    w_ones_cnt_nxt   = '0;
                end
            end
            S_SYNC: begin
                if (i_eop || w_stuff_err) begin
                    w_state_nxt = S_ERR;
                end else if (w_accept && (r_bit_cnt == 3'd7)) begin
                    w_state_nxt = S_CHK;
                end
            end
            S_CHK, S_RECV: begin
                if ((r_state == S_CHK) && !w_sync_ok) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_state_nxt = S_RECV;
                    if (i_eop) begin
                        if (r_bit_cnt == 3'd0) begin
                            w_packet_done_nxt = 1'b1;
                            w_state_nxt       = S_IDLE;
                        end else begin
                            w_state_nxt = S_ERR;
                        end
                    end else if (w_stuff_err) begin
                        w_state_nxt = S_ERR;
                    end else if (w_accept && (r_bit_cnt == 3'd7)) begin
                        if (r_byte_count == BC_W'(MAX_BYTES)) begin
                            w_state_nxt = S_ERR;
                        end else begin
                            w_byte_ready_nxt = 1'b1;
                            w_byte_count_nxt = r_byte_count + BC_W'(1);
                        end
                    end
                end
            end
            S_ERR: begin
                if (i_eop) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_timeout && w_active && !i_eop && !i_bit_strobe) begin
            w_state_nxt = S_ERR;
        end
        if (w_state_nxt == S_ERR) begin
            w_rx_error_nxt = 1'b1;
        end
        w_receiving_nxt = (w_state_nxt == S_SYNC) || (w_state_nxt == S_CHK) ||
                          (w_state_nxt == S_RECV);
    end

    assign o_shift_enable = w_shift;
    assign o_byte_ready   = r_byte_ready;
    assign o_packet_done  = r_packet_done;
    assign o_receiving    = r_receiving;
    assign o_rx_error     = r_rx_error;
    assign o_byte_count   = r_byte_count;
endmodule

// File: tb/tb_rx_shift_sequencer.sv
// Directed self-checking bench for rx_shift_sequencer with a model of the external shift register.
`timescale 1ns/1ps
module tb_rx_shift_sequencer;
    logic       clk = 1'b0;
    logic       n_rst;
    logic       start_detect, bit_strobe, d_bit, eop;
    logic [7:0] rx_byte;
    logic       shift_enable, byte_ready, packet_done, receiving, rx_error;
    logic [6:0] byte_count;

    int n_checks = 0;
    int n_errors = 0;
    int n_shift = 0;
    int n_br = 0;
    int n_pd = 0;
    logic [7:0] last_byte = 8'h00;
    int tb_ones = 0;

    rx_shift_sequencer dut (
        .clk(clk), .n_rst(n_rst), .i_start_detect(start_detect), .i_bit_strobe(bit_strobe),
        .i_d_bit(d_bit), .i_eop(eop), .i_rx_byte(rx_byte), .o_shift_enable(shift_enable),
        .o_byte_ready(byte_ready), .o_packet_done(packet_done), .o_receiving(receiving),
        .o_rx_error(rx_error), .o_byte_count(byte_count)
    );

    always #5 clk = ~clk;

    // LSB-first shift register fed by d_bit, reset to all ones
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) rx_byte <= 8'hFF;
        else if (shift_enable) rx_byte <= {d_bit, rx_byte[7:1]};
    end

    always @(negedge clk) begin
        if (shift_enable) n_shift++;
        if (byte_ready) begin
            n_br++;
            last_byte = rx_byte;
        end
        if (packet_done) n_pd++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0; start_detect = 1'b0; bit_strobe = 1'b0; d_bit = 1'b0; eop = 1'b0;
        tick(); tick();
        n_rst = 1'b1;
        tick();
    endtask

    task automatic send_bit(input logic b, input int gap, output logic se);
        bit_strobe = 1'b1; d_bit = b;
        #3 se = shift_enable;
        tick();
        bit_strobe = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap);
        logic se;
        for (int i = 0; i < 8; i++) begin
            send_bit(v[i], gap, se);
            if (v[i]) tb_ones++; else tb_ones = 0;
            if (tb_ones == 6) begin
                send_bit(1'b0, gap, se);
                tb_ones = 0;
            end
        end
    endtask

    task automatic pulse_start();
        start_detect = 1'b1; tick(); start_detect = 1'b0;
        tb_ones = 0;
    endtask

    task automatic pulse_eop();
        eop = 1'b1; tick(); eop = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (receiving !== 1'b0) begin n_errors++; $display("FAIL reset_receiving: got %b exp 0", receiving); end
        n_checks++; if (rx_error !== 1'b0) begin n_errors++; $display("FAIL reset_rx_error: got %b exp 0", rx_error); end
        n_checks++; if (byte_count !== 7'd0) begin n_errors++; $display("FAIL reset_byte_count: got %0d exp 0", byte_count); end
        n_checks++; if ({byte_ready, packet_done, shift_enable} !== 3'b000) begin n_errors++; $display("FAIL reset_pulses: got %b exp 000", {byte_ready, packet_done, shift_enable}); end
    endtask

    task automatic test_clean_packet();
        int s0, b0, p0;
        do_reset();
        s0 = n_shift; b0 = n_br; p0 = n_pd;
        pulse_start();
        n_checks++; if (receiving !== 1'b1) begin n_errors++; $display("FAIL clean_receiving: got %b exp 1", receiving); end
        send_byte(8'h80, 1);
        n_checks++; if (rx_byte !== 8'h80) begin n_errors++; $display("FAIL clean_sync_byte: got %h exp 80", rx_byte); end
        send_byte(8'hC3, 1);
        n_checks++; if (n_br - b0 !== 1 || last_byte !== 8'hC3) begin n_errors++; $display("FAIL clean_byte: got %0d/%h exp 1/c3", n_br - b0, last_byte); end
        n_checks++; if (byte_count !== 7'd1) begin n_errors++; $display("FAIL clean_byte_count: got %0d exp 1", byte_count); end
        pulse_eop();
        n_checks++; if (packet_done !== 1'b1 || receiving !== 1'b0) begin n_errors++; $display("FAIL clean_done: got %b/%b exp 1/0", packet_done, receiving); end
        tick();
        n_checks++; if (n_pd - p0 !== 1 || rx_error !== 1'b0) begin n_errors++; $display("FAIL clean_done_once: got %0d/%b exp 1/0", n_pd - p0, rx_error); end
        n_checks++; if (n_shift - s0 !== 16) begin n_errors++; $display("FAIL clean_shifts: got %0d exp 16", n_shift - s0); end
    endtask

    task automatic test_stuffing();
        logic se;
        int s0;
        logic [8:0] bits = 9'b110_111111;
        do_reset();
        pulse_start();
        send_byte(8'h80, 1);
        send_byte(8'h00, 1);
        s0 = n_shift;
        for (int i = 0; i < 9; i++) begin
            send_bit(bits[i], 1, se);
            if (i == 6) begin
                n_checks++; if (se !== 1'b0) begin n_errors++; $display("FAIL stuff_bit_shifted: got %b exp 0", se); end
            end
        end
        n_checks++; if (n_shift - s0 !== 8) begin n_errors++; $display("FAIL stuff_shift_count: got %0d exp 8", n_shift - s0); end
        n_checks++; if (last_byte !== 8'hFF || byte_count !== 7'd2) begin n_errors++; $display("FAIL stuff_byte: got %h/%0d exp ff/2", last_byte, byte_count); end
        pulse_eop();
        n_checks++; if (packet_done !== 1'b1 || rx_error !== 1'b0) begin n_errors++; $display("FAIL stuff_done: got %b/%b exp 1/0", packet_done, rx_error); end
    endtask

    task automatic test_stuff_error();
        logic se;
        do_reset();
        pulse_start();
        send_byte(8'h80, 1);
        send_bit(1'b0, 1, se);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1, se);
        bit_strobe = 1'b1; d_bit = 1'b1;
        #3 se = shift_enable;
        tick(); bit_strobe = 1'b0;
        n_checks++; if (se !== 1'b0) begin n_errors++; $display("FAIL stuff_err_shift: got %b exp 0", se); end
        n_checks++; if (rx_error !== 1'b1 || receiving !== 1'b0) begin n_errors++; $display("FAIL stuff_err_flag: got %b/%b exp 1/0", rx_error, receiving); end
        pulse_start();
        n_checks++; if (rx_error !== 1'b1 || receiving !== 1'b0) begin n_errors++; $display("FAIL err_start_ignored: got %b/%b exp 1/0", rx_error, receiving); end
        pulse_eop();
        n_checks++; if (rx_error !== 1'b1) begin n_errors++; $display("FAIL err_held_after_eop: got %b exp 1", rx_error); end
        pulse_start();
        n_checks++; if (rx_error !== 1'b0 || receiving !== 1'b1) begin n_errors++; $display("FAIL err_cleared_on_start: got %b/%b exp 0/1", rx_error, receiving); end
    endtask

    task automatic test_bad_sync();
        int b0;
        do_reset();
        b0 = n_br;
        pulse_start();
        send_byte(8'h81, 0);
        n_checks++; if (rx_error !== 1'b0 || receiving !== 1'b1) begin n_errors++; $display("FAIL bad_sync_chk: got %b/%b exp 0/1", rx_error, receiving); end
        tick();
        n_checks++; if (rx_error !== 1'b1 || receiving !== 1'b0) begin n_errors++; $display("FAIL bad_sync_err: got %b/%b exp 1/0", rx_error, receiving); end
        send_byte(8'h00, 1);
        n_checks++; if (n_br - b0 !== 0) begin n_errors++; $display("FAIL bad_sync_no_byte: got %0d exp 0", n_br - b0); end
    endtask

    task automatic test_mid_eop();
        logic se;
        int p0;
        do_reset();
        p0 = n_pd;
        pulse_start();
        send_byte(8'h80, 1);
        send_bit(1'b1, 1, se); send_bit(1'b0, 1, se); send_bit(1'b1, 1, se);
        pulse_eop();
        tick();
        n_checks++; if (rx_error !== 1'b1 || n_pd - p0 !== 0) begin n_errors++; $display("FAIL mid_eop: got %b/%0d exp 1/0", rx_error, n_pd - p0); end
    endtask

    task automatic test_overflow();
        int b0;
        do_reset();
        b0 = n_br;
        pulse_start();
        send_byte(8'h80, 1);
        for (int i = 0; i < 67; i++) send_byte(8'h00, 1);
        n_checks++; if (byte_count !== 7'd67 || rx_error !== 1'b0) begin n_errors++; $display("FAIL ovf_at_max: got %0d/%b exp 67/0", byte_count, rx_error); end
        send_byte(8'h00, 1);
        n_checks++; if (rx_error !== 1'b1 || byte_count !== 7'd67) begin n_errors++; $display("FAIL ovf_err: got %b/%0d exp 1/67", rx_error, byte_count); end
        n_checks++; if (n_br - b0 !== 67) begin n_errors++; $display("FAIL ovf_ready_count: got %0d exp 67", n_br - b0); end
    endtask

    task automatic test_back_to_back();
        logic se;
        int s0, b0;
        do_reset();
        s0 = n_shift; b0 = n_br;
        pulse_start();
        send_byte(8'h80, 0);
        send_byte(8'hC3, 0);
        tick();
        n_checks++; if (n_br - b0 !== 1 || last_byte !== 8'hC3) begin n_errors++; $display("FAIL b2b_byte: got %0d/%h exp 1/c3", n_br - b0, last_byte); end
        eop = 1'b1; bit_strobe = 1'b1; d_bit = 1'b1;
        #3 se = shift_enable;
        tick(); eop = 1'b0; bit_strobe = 1'b0;
        n_checks++; if (se !== 1'b0 || n_shift - s0 !== 16) begin n_errors++; $display("FAIL b2b_eop_wins: got %b/%0d exp 0/16", se, n_shift - s0); end
        n_checks++; if (packet_done !== 1'b1 || rx_error !== 1'b0) begin n_errors++; $display("FAIL b2b_done: got %b/%b exp 1/0", packet_done, rx_error); end
    endtask

    task automatic test_reset_mid();
        logic se;
        do_reset();
        pulse_start();
        send_byte(8'h80, 1);
        send_byte(8'h00, 1);
        send_bit(1'b1, 1, se); send_bit(1'b0, 1, se);
        n_checks++; if (byte_count !== 7'd1 || receiving !== 1'b1) begin n_errors++; $display("FAIL rst_pre: got %0d/%b exp 1/1", byte_count, receiving); end
        bit_strobe = 1'b1; d_bit = 1'b1;
        n_rst = 1'b0;
        #1;
        n_checks++; if ({receiving, rx_error, byte_ready, packet_done, shift_enable} !== 5'b0 || byte_count !== 7'd0) begin n_errors++; $display("FAIL rst_mid: got %b/%0d exp 00000/0", {receiving, rx_error, byte_ready, packet_done, shift_enable}, byte_count); end
        bit_strobe = 1'b0;
        tick();
        n_rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_clean_packet();
        test_stuffing();
        test_stuff_error();
        test_bad_sync();
        test_mid_eop();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rx_shift_sequencer.md
Name: rx_shift_sequencer

Overview:
- Controls the 8-bit serial-to-parallel receive shift register (shift-right/LSB-first, resets to all ones) in the USB RX path.
- Gates shift_enable from the decoded bit stream, removes stuffed bits, and counts bits into bytes.
- Checks the SYNC byte, detects EOP framing and byte-count overflow, and flags byte_ready whenever a full byte sits on the shift register output.
- Sits between the NRZI decoder/edge detector and the RX FIFO/PID logic.

Parameters:
SYNC_BYTE, 8'h80, required value of the shift register after the first 8 unstuffed bits
STUFF_LEN, 6, consecutive accepted 1s after which the next bit is a stuff bit
MAX_BYTES, 67, max bytes after SYNC (PID + 64 data + 2 CRC); the next completed byte is an overflow error
TIMEOUT_CYCLES, 64, idle-bit timeout in clk cycles; used only with RX_TIMEOUT_EN

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
start_detect  input  1  1-cycle pulse: first K-to-J transition of a packet
bit_strobe  input  1  1-cycle pulse: d_bit valid this cycle
d_bit  input  1  decoded bit; also wired directly to the shift register serial_in
eop  input  1  1-cycle pulse: end-of-packet detected
rx_byte  input  8  shift register parallel_out
shift_enable  output  1  combinational shift command to the shift register
byte_ready  output  1  registered 1-cycle pulse: rx_byte holds a new payload byte
packet_done  output  1  registered 1-cycle pulse: clean EOP on a byte boundary
receiving  output  1  high in SYNC, CHK, RECV
rx_error  output  1  sticky error flag
byte_count  output  $clog2(MAX_BYTES+1)  payload bytes completed this packet

Behaviour:
- Reset: state IDLE, bit_cnt=0, ones_cnt=0, byte_count=0, all outputs 0.
- States: IDLE, SYNC, CHK, RECV, ERR.
- IDLE:
  - start_detect -> SYNC; clears rx_error, byte_count, bit_cnt, ones_cnt.
  - A bit_strobe in the same cycle is not shifted.
- Bit acceptance (SYNC, RECV only), evaluated in this priority order:
  1. eop wins over bit_strobe; the bit is ignored.
  2. bit_strobe with ones_cnt==STUFF_LEN is a stuff bit. d_bit=0: dropped, shift_enable=0, ones_cnt=0. d_bit=1: stuff error -> ERR.
  3. Otherwise shift_enable=1 in the same cycle. ones_cnt increments on 1 and clears on 0. bit_cnt increments mod 8.
- SYNC:
  - Accepted bit with bit_cnt==7 -> CHK.
  - eop -> ERR.
- CHK (1 cycle; rx_byte is now valid):
  - rx_byte==SYNC_BYTE -> RECV.
  - Otherwise -> ERR.
  - A bit_strobe during CHK is processed as in RECV, so strobes may be 1 cycle apart.
- RECV:
  - Accepted bit with bit_cnt==7: byte_ready=1 in the next cycle. byte_count increments in the same cycle as byte_ready.
  - If byte_count==MAX_BYTES when a byte completes: no byte_ready, -> ERR.
  - eop with bit_cnt==0: packet_done=1 in the next cycle -> IDLE.
  - eop with bit_cnt!=0: -> ERR.
- ERR:
  - rx_error=1, shift_enable=0.
  - eop -> IDLE with rx_error held. rx_error clears on the next start_detect.
  - start_detect in ERR is ignored.
- bit_cnt and ones_cnt carry across byte boundaries; stuffing spans bytes.
- Reset mid-packet: immediate return to reset values; no pulses emitted.
- byte_count saturates at MAX_BYTES.

Optional Feature:
- Macro RX_TIMEOUT_EN.
- Defined: an idle counter runs in SYNC/CHK/RECV and clears on any bit_strobe. When it reaches TIMEOUT_CYCLES-1 without a strobe -> ERR. Example: 64 idle cycles -> rx_error on cycle 64.
- Undefined: no counter logic; the block waits indefinitely for eop.

Test Plan:
- Clean packet:
  - Stimulus: start_detect, 8 strobes 0,0,0,0,0,0,0,1, then PID bits of 0xC3 LSB-first, then eop at bit_cnt=0.
  - Required: CHK passes (rx_byte=0x80); byte_ready once with rx_byte=0xC3; byte_count=1; packet_done 1 cycle after eop; rx_error=0.
- Stuffing:
  - Stimulus: data 0xFF sent as 1x6, stuff 0, 1,1.
  - Required: exactly 8 shift_enable pulses; stuff bit not shifted; rx_byte=0xFF at byte_ready.
- Stuff error:
  - Stimulus: seven consecutive 1s.
  - Required: shift_enable=0 on the 7th; ERR; rx_error=1 until eop then next start_detect.
- Bad SYNC:
  - Stimulus: first byte 0x81.
  - Required: CHK -> ERR; no byte_ready.
- Mid-byte EOP and overflow:
  - Stimulus: eop after 3 payload bits. Separately, 68 payload bytes.
  - Required: rx_error=1 in both. byte_ready count=67, byte_count=67.
- Back-to-back/simultaneous events and reset:
  - Stimulus: strobes 1 cycle apart through CHK; eop coincident with bit_strobe; n_rst low mid-byte.
  - Required: no lost bits; eop wins; all outputs 0 immediately on reset.
